// File: rtl/idli_fetch_pkg.sv
`default_nettype none
// ==== idli_fetch_pkg : shared fetch-stage types (FSM state, buffer entry) -- rev 1.0 ====
package idli_fetch_pkg;

  typedef enum logic [0:0] {
    FETCH_STATE_STREAM  = 1'b0,
    FETCH_STATE_RESTART = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/idli_fetch_buf_m.sv
`default_nettype none
// ==== idli_fetch_buf_m : DEPTH-entry instruction FIFO, flush beats push -- rev 1.0 ====
module idli_fetch_buf_m
  import idli_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/idli_fetch_m.sv
`default_nettype none
// ==== idli_fetch_m : SQI nibble stream -> 16b instruction words with restart control -- rev 1.0 ====
module idli_fetch_m
  import idli_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_fetch_gck,
  input  logic        i_fetch_rst,
  input  logic        i_fetch_ctr_last_cycle,
  input  logic        i_fetch_sqi_vld,
  input  logic [3:0]  i_fetch_sqi_data,
  output logic        o_fetch_instr_vld,
  output logic [15:0] o_fetch_instr,
  output logic [15:0] o_fetch_instr_pc,
  input  logic        i_fetch_instr_rdy,
  input  logic        i_fetch_redirect,
  input  logic [15:0] i_fetch_redirect_pc,
  output logic        o_fetch_restart,
  output logic [15:0] o_fetch_addr
);

  fetch_state_e state;
  logic [15:0]  asm_q;
  logic [15:0]  fetch_pc;
  logic [15:0]  word;
  logic [15:0]  redirect_pc;
  logic         word_done;
  logic         streaming;
  logic         pop;
  logic         push;
  logic         overflow;
  logic         full;
  logic         empty;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic [4:0]   unused_bits;

  assign word        = {asm_q[11:0], i_fetch_sqi_data};
  assign word_done   = i_fetch_sqi_vld & i_fetch_ctr_last_cycle;
  assign streaming   = (state == FETCH_STATE_STREAM);
  assign redirect_pc = {i_fetch_redirect_pc[15:1], 1'b0};
  assign pop         = i_fetch_instr_rdy & ~empty;
  // A redirect in the same cycle wins over both a push and an overflow.
  assign push        = streaming & ~i_fetch_redirect & word_done & (~full | pop);
  assign overflow    = streaming & ~i_fetch_redirect & word_done & full & ~pop;
  assign push_data   = '{instr: word, pc: fetch_pc};
  assign unused_bits = {asm_q[15:12], i_fetch_redirect_pc[0]};

  idli_fetch_buf_m #(.DEPTH(DEPTH)) u_buf (
    .clk       (i_fetch_gck),
    .rst       (i_fetch_rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (i_fetch_redirect),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign o_fetch_instr_vld = ~empty;
  assign o_fetch_instr     = head.instr;
  assign o_fetch_instr_pc  = head.pc;

  always_ff @(posedge i_fetch_gck or posedge i_fetch_rst) begin
    if (i_fetch_rst) begin
      state           <= FETCH_STATE_STREAM;
      asm_q           <= '0;
      fetch_pc        <= RESET_PC;
      o_fetch_addr    <= RESET_PC;
      o_fetch_restart <= 1'b0;
    end else begin
      if (i_fetch_redirect) begin
        fetch_pc     <= redirect_pc;
        o_fetch_addr <= redirect_pc;
      end else if (push) begin
        fetch_pc     <= fetch_pc + 16'd2;
      end else if (overflow) begin
        o_fetch_addr <= fetch_pc;
      end

      if (streaming) begin
        if (i_fetch_redirect || overflow) begin
          state           <= FETCH_STATE_RESTART;
          o_fetch_restart <= 1'b1;
          asm_q           <= '0;
        end else if (i_fetch_sqi_vld) begin
          asm_q <= word;
        end
      end else begin
        // SQI control re-latches INIT on the next period boundary.
        asm_q <= '0;
        if (i_fetch_ctr_last_cycle) begin
          state           <= FETCH_STATE_STREAM;
          o_fetch_restart <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idli_fetch_m.sv
`default_nettype none
// ==== tb_idli_fetch_m : directed scenarios plus randomized run against a queue-based model -- rev 1.0 ====
module tb_idli_fetch_m;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        last = 1'b0;
  logic        sqi_vld = 1'b0;
  logic [3:0]  data = '0;
  logic        rdy = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] rpc = '0;
  logic        instr_vld;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        restart;
  logic [15:0] addr;

  int total = 0;
  int bad = 0;
  int phase = 0;

  // Behavioural model: queue of {instr, pc}, restart flag, addresses, nibble history.
  logic [31:0] mq[$];
  bit          m_restart;
  logic [15:0] m_addr;
  logic [15:0] m_pc;
  logic [15:0] m_hist;

  always #5 clk = ~clk;

  idli_fetch_m #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_fetch_gck            (clk),
    .i_fetch_rst            (rst),
    .i_fetch_ctr_last_cycle (last),
    .i_fetch_sqi_vld        (sqi_vld),
    .i_fetch_sqi_data       (data),
    .o_fetch_instr_vld      (instr_vld),
    .o_fetch_instr          (instr),
    .o_fetch_instr_pc       (instr_pc),
    .i_fetch_instr_rdy      (rdy),
    .i_fetch_redirect       (redirect),
    .i_fetch_redirect_pc    (rpc),
    .o_fetch_restart        (restart),
    .o_fetch_addr           (addr)
  );

  function automatic void model_reset();
    mq.delete();
    m_restart = 1'b0;
    m_addr    = RESET_PC;
    m_pc      = RESET_PC;
    m_hist    = '0;
  endfunction

  function automatic void model_step();
    logic [15:0] w;
    bit was_restart;
    w = {m_hist[11:0], data};
    was_restart = m_restart;
    if (redirect) begin
      mq.delete();
      m_pc   = {rpc[15:1], 1'b0};
      m_addr = m_pc;
    end else if (rdy && mq.size() > 0) begin
      void'(mq.pop_front());
    end
    if (was_restart) begin
      m_hist = '0;
      if (last) m_restart = 1'b0;
    end else if (redirect) begin
      m_restart = 1'b1;
      m_hist    = '0;
    end else begin
      if (sqi_vld && last) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({w, m_pc});
          m_pc = m_pc + 16'd2;
        end else begin
          m_restart = 1'b1;
          m_addr    = m_pc;
        end
      end
      if (sqi_vld) m_hist = w;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    phase = (phase + 1) % 4;
    last  = (phase == 3);
  endtask

  task automatic apply_reset();
    rst = 1'b1; sqi_vld = 1'b0; rdy = 1'b0; redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit rdy_pre, input bit rdy_last);
    sqi_vld = 1'b0;
    rdy = rdy_pre;
    while (phase != 0) tick();
    for (int i = 0; i < 4; i++) begin
      sqi_vld = 1'b1;
      data = w[15-4*i -: 4];
      rdy = (i == 3) ? rdy_last : rdy_pre;
      tick();
    end
    sqi_vld = 1'b0;
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b exp=0", instr_vld); end
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL reset_restart got=%0b exp=0", restart); end
    total++; if (addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", addr, RESET_PC); end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    apply_reset();
    send_word(16'h1234, 1'b1, 1'b1);
    total++; if (instr_vld !== 1'b1) begin bad++; $display("FAIL stream_vld got=%0b exp=1", instr_vld); end
    total++; if (instr !== 16'h1234) begin bad++; $display("FAIL stream_instr got=%h exp=1234", instr); end
    total++; if (instr_pc !== 16'h0000) begin bad++; $display("FAIL stream_pc got=%h exp=0000", instr_pc); end
    send_word(16'hABCD, 1'b1, 1'b1);
    total++; if (instr !== 16'hABCD) begin bad++; $display("FAIL stream_instr2 got=%h exp=abcd", instr); end
    total++; if (instr_pc !== 16'h0002) begin bad++; $display("FAIL stream_pc2 got=%h exp=0002", instr_pc); end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b exp=0", instr_vld); end
  endtask

  task automatic test_overflow();
    apply_reset();
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 1'b0);
    send_word(16'h9ABC, 1'b0, 1'b0);
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL ovf_restart got=%0b exp=1", restart); end
    total++; if (addr !== 16'h0004) begin bad++; $display("FAIL ovf_addr got=%h exp=0004", addr); end
    total++; if (instr !== 16'h1234 || instr_pc !== 16'h0000) begin bad++; $display("FAIL ovf_head got=%h@%h exp=1234@0000", instr, instr_pc); end
    tick(); tick(); tick();
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%0b exp=1", restart); end
    tick();
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL ovf_exit got=%0b exp=0", restart); end
    total++; if (addr !== 16'h0004) begin bad++; $display("FAIL ovf_addr_held got=%h exp=0004", addr); end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    total++; if (instr !== 16'h5678 || instr_pc !== 16'h0002) begin bad++; $display("FAIL ovf_pop got=%h@%h exp=5678@0002", instr, instr_pc); end
    send_word(16'hCAFE, 1'b0, 1'b0);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    total++; if (instr !== 16'hCAFE || instr_pc !== 16'h0004) begin bad++; $display("FAIL ovf_refetch got=%h@%h exp=cafe@0004", instr, instr_pc); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    send_word(16'h3333, 1'b0, 1'b1);
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL fullpop_restart got=%0b exp=0", restart); end
    total++; if (instr !== 16'h2222 || instr_pc !== 16'h0002) begin bad++; $display("FAIL fullpop_head got=%h@%h exp=2222@0002", instr, instr_pc); end
    rdy = 1'b1;
    tick();
    total++; if (instr !== 16'h3333 || instr_pc !== 16'h0004) begin bad++; $display("FAIL fullpop_next got=%h@%h exp=3333@0004", instr, instr_pc); end
    tick();
    rdy = 1'b0;
    total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL fullpop_occ got=%0b exp=0", instr_vld); end
  endtask

  task automatic test_redirect();
    apply_reset();
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    redirect = 1'b1;
    rpc = 16'h0101;
    tick();
    redirect = 1'b0;
    total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL redir_flush got=%0b exp=0", instr_vld); end
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL redir_restart got=%0b exp=1", restart); end
    total++; if (addr !== 16'h0100) begin bad++; $display("FAIL redir_addr got=%h exp=0100", addr); end
    send_word(16'hBEEF, 1'b0, 1'b0);
    total++; if (instr !== 16'hBEEF || instr_pc !== 16'h0100) begin bad++; $display("FAIL redir_word got=%h@%h exp=beef@0100", instr, instr_pc); end
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL redir_exit got=%0b exp=0", restart); end
  endtask

  task automatic test_partial();
    apply_reset();
    while (phase != 0) tick();
    sqi_vld = 1'b1; data = 4'hF; tick();
    data = 4'hE; tick();
    sqi_vld = 1'b0; tick(); tick();
    total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL partial_nopush got=%0b exp=0", instr_vld); end
    send_word(16'h4321, 1'b0, 1'b0);
    total++; if (instr !== 16'h4321 || instr_pc !== 16'h0000) begin bad++; $display("FAIL partial_clean got=%h@%h exp=4321@0000", instr, instr_pc); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 1'b0);
    send_word(16'h9ABC, 1'b0, 1'b0);
    total++; if (restart !== 1'b1 || instr_vld !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0b/%0b exp=1/1", restart, instr_vld); end
    #2 rst = 1'b1;
    #1;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL midrst_restart got=%0b exp=0", restart); end
    total++; if (instr_vld !== 1'b0) begin bad++; $display("FAIL midrst_vld got=%0b exp=0", instr_vld); end
    total++; if (addr !== RESET_PC) begin bad++; $display("FAIL midrst_addr got=%h exp=%h", addr, RESET_PC); end
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] e;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      sqi_vld  = ($urandom_range(0, 9) < 8);
      data     = 4'($urandom);
      rdy      = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 49) == 0);
      rpc      = 16'($urandom);
      tick();
      total++; if (instr_vld !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_vld n=%0d got=%0b exp=%0b", n, instr_vld, mq.size() > 0); end
      if (mq.size() > 0) begin
        e = mq[0];
        total++; if ({instr, instr_pc} !== e) begin bad++; $display("FAIL rnd_head n=%0d got=%h@%h exp=%h@%h", n, instr, instr_pc, e[31:16], e[15:0]); end
      end
      total++; if (restart !== m_restart) begin bad++; $display("FAIL rnd_restart n=%0d got=%0b exp=%0b", n, restart, m_restart); end
      total++; if (addr !== m_addr) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, addr, m_addr); end
    end
    sqi_vld = 1'b0; rdy = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_overflow();
    test_full_pop();
    test_redirect();
    test_partial();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
